// File: rtl/nv_ram_rwsp_param.sv
// Parametrised 1W/1R synchronous RAM with segment write mask, selectable
// read-during-write behaviour, optional output register and read-valid flag.
module nv_ram_rwsp_param #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 116,
  parameter int AW     = $clog2(DEPTH),
  parameter int SEGS   = 1,
  parameter int PIPE   = 0,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [SEGS-1:0]  wmask,
  input  logic [WIDTH-1:0] di,
  input  logic [31:0]      pwrbus_ram_pd
);

  localparam int SW = WIDTH / SEGS;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             sleep;
  logic             ra_ok;
  logic             wa_ok;
  logic             re_acc;
  logic             we_acc;
  logic             hit;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_next;
  logic [WIDTH-1:0] rd_q;
  logic             rd_vld_q;
  logic             unused_pd;

  assign sleep     = pwrbus_ram_pd[0];
  assign unused_pd = ^pwrbus_ram_pd[31:1];

  // Address range checks collapse to constants when DEPTH fills the address space.
  generate
    if (DEPTH == (1 << AW)) begin : g_full_range
      assign ra_ok = 1'b1;
      assign wa_ok = 1'b1;
    end else begin : g_part_range
      assign ra_ok = (ra < AW'(DEPTH));
      assign wa_ok = (wa < AW'(DEPTH));
    end
  endgenerate

  assign re_acc  = re & ~sleep;
  assign we_acc  = we & ~sleep & wa_ok;
  assign hit     = (BYPASS != 0) && we_acc && re_acc && (wa == ra);
  assign rd_word = ra_ok ? mem[ra] : '0;

  always_comb begin
    rd_next = rd_word;
    for (int i = 0; i < SEGS; i++) begin
      if (hit && wmask[i]) rd_next[i*SW +: SW] = di[i*SW +: SW];
    end
  end

  always_ff @(posedge clk) begin
    if (we_acc) begin
      for (int i = 0; i < SEGS; i++) begin
        if (wmask[i]) mem[wa][i*SW +: SW] <= di[i*SW +: SW];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q     <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= re_acc;
      if (re_acc) rd_q <= rd_next;
    end
  end

  generate
    if (PIPE != 0) begin : g_pipe
      logic [WIDTH-1:0] dout_q;
      logic             dout_vld_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          dout_q     <= '0;
          dout_vld_q <= 1'b0;
        end else begin
          dout_vld_q <= rd_vld_q;
          if (rd_vld_q) dout_q <= rd_q;
        end
      end

      assign dout     = dout_q;
      assign dout_vld = dout_vld_q;
    end else begin : g_nopipe
      assign dout     = rd_q;
      assign dout_vld = rd_vld_q;
    end
  endgenerate

endmodule
